mdu: RTL and testbench

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations into architectural HI/LO registers, and MTHI/MTLO as single-cycle writes.
- Drives busy, which the hazard unit uses to stall MFHI/MFLO and further MD instructions.
- HI and LO feed the EX-stage 32-bit 4:1 result-select mux that chooses among ALU result, HI, LO and PC+8.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu.sv | 131 +++++++++++++
 tb/tb_mdu.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared definitions: op codes and small helpers.
// Shared with the decoder that generates the mdu op field.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit with architectural HI/LO and busy.
// Optional MADD/MADDU accumulate enabled by defining MDU_MADD_EN.
import mdu_pkg::*;

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [3:0]  cnt;
  logic [31:0] phi, plo;
  logic        pwr;

  logic [3:0]  n_cnt;
  logic [31:0] n_hi, n_lo;
  logic        n_wr, mthi, mtlo;

  logic [63:0] smul, umul;
  logic [31:0] dvs, uq, ur;
  logic [31:0] ua, ub, ubz, mq, mr, sq, sr;
  logic        ovf;

  assign busy = (cnt != 4'd0);

  assign umul = {32'd0, a} * {32'd0, b};
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Divisor of zero never commits; substitute 1 to keep the divider defined.
  assign dvs = (b == 32'd0) ? 32'd1 : b;
  assign uq  = a / dvs;
  assign ur  = a % dvs;

  assign ua  = a[31] ? neg32(a) : a;
  assign ub  = b[31] ? neg32(b) : b;
  assign ubz = (ub == 32'd0) ? 32'd1 : ub;
  assign mq  = ua / ubz;
  assign mr  = ua % ubz;
  assign sq  = (a[31] ^ b[31]) ? neg32(mq) : mq;
  assign sr  = a[31] ? neg32(mr) : mr;
  assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    n_cnt = 4'd0;
    n_hi  = 32'd0;
    n_lo  = 32'd0;
    n_wr  = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    unique case (1'b1)
      (op == MDU_MULT): begin
        n_cnt        = 4'(MULT_CYCLES);
        {n_hi, n_lo} = smul;
        n_wr         = 1'b1;
      end
      (op == MDU_MULTU): begin
        n_cnt        = 4'(MULT_CYCLES);
        {n_hi, n_lo} = umul;
        n_wr         = 1'b1;
      end
      (op == MDU_DIV): begin
        n_cnt = 4'(DIV_CYCLES);
        n_wr  = (b != 32'd0);
        if (ovf) begin
          n_lo = 32'h8000_0000;
          n_hi = 32'd0;
        end else begin
          n_lo = sq;
          n_hi = sr;
        end
      end
      (op == MDU_DIVU): begin
        n_cnt = 4'(DIV_CYCLES);
        n_wr  = (b != 32'd0);
        n_lo  = uq;
        n_hi  = ur;
      end
      (op == MDU_MTHI): mthi = 1'b1;
      (op == MDU_MTLO): mtlo = 1'b1;
`ifdef MDU_MADD_EN
      (op == MDU_MADD): begin
        n_cnt        = 4'(MULT_CYCLES);
        {n_hi, n_lo} = {hi, lo} + smul;
        n_wr         = 1'b1;
      end
      (op == MDU_MADDU): begin
        n_cnt        = 4'(MULT_CYCLES);
        {n_hi, n_lo} = {hi, lo} + umul;
        n_wr         = 1'b1;
      end
`endif
      default: begin
        n_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
      phi <= 32'd0;
      plo <= 32'd0;
      pwr <= 1'b0;
      hi  <= 32'd0;
      lo  <= 32'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pwr) begin
        hi <= phi;
        lo <= plo;
      end
    end else if (start) begin
      cnt <= n_cnt;
      phi <= n_hi;
      plo <= n_lo;
      pwr <= n_wr;
      if (mthi) hi <= a;
      if (mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus random ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int nchk = 0;
  int nfail = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic model_apply(input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, output int n);
    logic [63:0] p, ux, uy;
    longint sp;
    int sx, sy;
    n = 0;
    sx = x;
    sy = y;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        {mhi, mlo} = sp;
        n = 5;
      end
      3'd1: begin
        p = ux * uy;
        {mhi, mlo} = p;
        n = 5;
      end
      3'd2: begin
        n = 10;
        if (y != 0) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            mlo = 32'h8000_0000;
            mhi = 32'd0;
          end else begin
            mlo = sx / sy;
            mhi = sx % sy;
          end
        end
      end
      3'd3: begin
        n = 10;
        if (y != 0) begin
          mlo = x / y;
          mhi = x % y;
        end
      end
      3'd4: mhi = x;
      3'd5: mlo = x;
      default: begin
`ifdef MDU_MADD_EN
        n = 5;
        if (o == 3'd6) sp = longint'(sx) * longint'(sy);
        else sp = longint'(ux * uy);
        {mhi, mlo} = {mhi, mlo} + 64'(sp);
`endif
      end
    endcase
  endtask

  // Issue one op, scramble operands after accept, count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int nb);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic check_hilo(input string nm, input int nb, input int en);
    nchk++;
    if (nb !== en) begin
      nfail++;
      $display("FAIL %s busy cycles got %0d want %0d", nm, nb, en);
    end
    nchk++;
    if (hi !== mhi || lo !== mlo) begin
      nfail++;
      $display("FAIL %s hi/lo got %h/%h want %h/%h", nm, hi, lo, mhi, mlo);
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      nfail++;
      $display("FAIL reset got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mhi = 0;
    mlo = 0;
  endtask

  task automatic test_mult;
    int nb, en;
    model_apply(3'd0, 32'hFFFF_FFFE, 32'd3, en);
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, nb);
    nchk++;
    if (nb !== 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      nfail++;
      $display("FAIL mult got n=%0d %h/%h want 5 ffffffff/fffffffa", nb, hi, lo);
    end
    model_apply(3'd1, 32'hFFFF_FFFE, 32'd3, en);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, nb);
    nchk++;
    if (nb !== 5 || hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
      nfail++;
      $display("FAIL multu got n=%0d %h/%h want 5 00000002/fffffffa", nb, hi, lo);
    end
  endtask

  task automatic test_div;
    int nb, en;
    model_apply(3'd2, 32'hFFFF_FFF9, 32'd2, en);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb);
    nchk++;
    if (nb !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL div got n=%0d %h/%h want 10 ffffffff/fffffffd", nb, hi, lo);
    end
    model_apply(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, en);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    nchk++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      nfail++;
      $display("FAIL div_ovf got %h/%h want 00000000/80000000", hi, lo);
    end
    check_hilo("div_ovf_model", nb, en);
  endtask

  task automatic test_divzero_mt;
    int nb, en;
    model_apply(3'd4, 32'h1111_1111, 32'd0, en);
    run_op(3'd4, 32'h1111_1111, 32'd0, nb);
    model_apply(3'd5, 32'h2222_2222, 32'd0, en);
    run_op(3'd5, 32'h2222_2222, 32'd0, nb);
    model_apply(3'd3, 32'd100, 32'd0, en);
    run_op(3'd3, 32'd100, 32'd0, nb);
    nchk++;
    if (nb !== 10 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      nfail++;
      $display("FAIL divu0 got n=%0d %h/%h want 10 11111111/22222222", nb, hi, lo);
    end
    model_apply(3'd4, 32'hDEAD_BEEF, 32'd0, en);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, nb);
    nchk++;
    if (nb !== 0 || hi !== 32'hDEAD_BEEF) begin
      nfail++;
      $display("FAIL mthi got n=%0d hi=%h want 0 deadbeef", nb, hi);
    end
  endtask

  task automatic test_ignore;
    int nb, en;
    model_apply(3'd0, 32'd3, 32'd4, en);
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    a = 32'd3;
    b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      start = (nb == 2 || nb == 3);
      op = (nb == 2) ? 3'd2 : 3'd5;
      a = 32'h5555_AAAA;
      b = 32'd9;
      @(negedge clk);
    end
    start = 1'b0;
    nchk++;
    if (nb !== 5 || hi !== 32'd0 || lo !== 32'd12) begin
      nfail++;
      $display("FAIL ignore got n=%0d %h/%h want 5 00000000/0000000c", nb, hi, lo);
    end
    check_hilo("ignore_model", nb, en);
  endtask

  task automatic test_reset_mid;
    int nb;
    @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    a = 32'd50;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nb = 1;
    while (nb < 4) begin
      nb++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      nfail++;
      $display("FAIL rst_mid got busy=%b %h/%h want 0 0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mhi = 0;
    mlo = 0;
    repeat (12) @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      nfail++;
      $display("FAIL rst_late got busy=%b %h/%h want 0 0/0", busy, hi, lo);
    end
  endtask

  task automatic test_madd;
    int nb, en;
    model_apply(3'd4, 32'd0, 32'd0, en);
    run_op(3'd4, 32'd0, 32'd0, nb);
    model_apply(3'd5, 32'hFFFF_FFFF, 32'd0, en);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, nb);
    model_apply(3'd7, 32'd1, 32'd1, en);
    run_op(3'd7, 32'd1, 32'd1, nb);
    nchk++;
`ifdef MDU_MADD_EN
    if (nb !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
      nfail++;
      $display("FAIL maddu got n=%0d %h/%h want 5 00000001/00000000", nb, hi, lo);
    end
`else
    if (nb !== 0 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL maddu_nop got n=%0d %h/%h want 0 00000000/ffffffff", nb, hi, lo);
    end
`endif
  endtask

  task automatic test_random;
    int nb, en;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 7) == 0) x = -32'($urandom_range(1, 99));
      model_apply(o, x, y, en);
      run_op(o, x, y, nb);
      check_hilo($sformatf("rand%0d_op%0d", i, o), nb, en);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero_mt;
    test_ignore;
    test_reset_mid;
    test_madd;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
